// File: rtl/clk_div_cfg_sched.sv
`default_nettype none
// clk_div_cfg_sched: round-robin arbiter for two divider-update requesters that
// writes the clock-generator register, waits SETTLE cycles, reads back and retries on mismatch.
module clk_div_cfg_sched #(
  parameter int unsigned RETRY_MAX = 2,
  parameter int unsigned SETTLE    = 1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        R0_REQ,
  input  logic [3:0]  R0_ADDR,
  input  logic [15:0] R0_DATA,
  output logic        R0_ACK,
  input  logic        R1_REQ,
  input  logic [3:0]  R1_ADDR,
  input  logic [15:0] R1_DATA,
  output logic        R1_ACK,
  output logic [3:0]  CG_ADDR,
  output logic [15:0] CG_DI,
  output logic        CG_WE,
  output logic        CG_RE,
  input  logic [31:0] CG_DO,
  output logic        BUSY,
  output logic        ERR,
  output logic [1:0]  ERR_CODE
);

  localparam int unsigned   RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX      = RW'(RETRY_MAX);
  localparam logic [3:0]    SETTLE_M1 = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WRITE, S_SETTLE, S_READ, S_CHECK, S_RESP
  } state_t;

  state_t          state_q;
  logic            last_q;
  logic            sel_q;
  logic [3:0]      addr_q;
  logic [15:0]     data_q;
  logic [15:0]     rd_q;
  logic [3:0]      cnt_q;
  logic [RW-1:0]   retry_q;

  logic            win;
  logic            addr_ok;
  logic            data_ok;
  logic [15:0]     unused_do_hi;

  // Requester 1 wins only if alone or if requester 0 was granted last.
  assign win          = R1_REQ & (~R0_REQ | ~last_q);
  assign addr_ok      = (addr_q != 4'h1) && (addr_q[3] == 1'b0);
  assign data_ok      = (data_q != 16'h0000) || (addr_q == 4'h5);
  assign BUSY         = (state_q != S_IDLE);
  assign unused_do_hi = CG_DO[31:16];

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      addr_q   <= 4'h0;
      data_q   <= 16'h0000;
      rd_q     <= 16'h0000;
      cnt_q    <= 4'h0;
      retry_q  <= '0;
      R0_ACK   <= 1'b0;
      R1_ACK   <= 1'b0;
      CG_ADDR  <= 4'h0;
      CG_DI    <= 16'h0000;
      CG_WE    <= 1'b0;
      CG_RE    <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= 2'b00;
    end else begin
      R0_ACK  <= 1'b0;
      R1_ACK  <= 1'b0;
      CG_WE   <= 1'b0;
      CG_RE   <= 1'b0;
      CG_ADDR <= 4'h0;
      CG_DI   <= 16'h0000;
      case (state_q)
        S_IDLE: begin
          if (R0_REQ || R1_REQ) begin
            sel_q   <= win;
            last_q  <= win;
            addr_q  <= win ? R1_ADDR : R0_ADDR;
            data_q  <= win ? R1_DATA : R0_DATA;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!addr_ok || !data_ok) begin
            state_q  <= S_RESP;
            R0_ACK   <= ~sel_q;
            R1_ACK   <= sel_q;
            ERR      <= 1'b1;
            ERR_CODE <= addr_ok ? 2'b10 : 2'b01;
          end else begin
            state_q <= S_WRITE;
            CG_WE   <= 1'b1;
            CG_ADDR <= addr_q;
            CG_DI   <= data_q;
          end
        end
        S_WRITE: begin
          if (SETTLE == 0) begin
            state_q <= S_READ;
            CG_RE   <= 1'b1;
            CG_ADDR <= addr_q;
          end else begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_M1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'h0) begin
            state_q <= S_READ;
            CG_RE   <= 1'b1;
            CG_ADDR <= addr_q;
          end else begin
            cnt_q <= cnt_q - 4'h1;
          end
        end
        S_READ: begin
          rd_q    <= CG_DO[15:0];
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (rd_q == data_q) begin
            state_q  <= S_RESP;
            R0_ACK   <= ~sel_q;
            R1_ACK   <= sel_q;
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
          end else if (retry_q < RMAX) begin
            retry_q <= retry_q + 1'b1;
            state_q <= S_WRITE;
            CG_WE   <= 1'b1;
            CG_ADDR <= addr_q;
            CG_DI   <= data_q;
          end else begin
            state_q  <= S_RESP;
            R0_ACK   <= ~sel_q;
            R1_ACK   <= sel_q;
            ERR      <= 1'b1;
            ERR_CODE <= 2'b11;
          end
        end
        S_RESP: begin
          retry_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_cfg_sched.sv
`default_nettype none
// tb_clk_div_cfg_sched: transaction-level schedule model of the divider scheduler,
// directed scenarios followed by randomized traffic from both requesters.
module tb_clk_div_cfg_sched;

  localparam int RM = 2;
  localparam int S  = 1;
  localparam int NC = 16384;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b0;
  logic        R0_REQ = 1'b0, R1_REQ = 1'b0;
  logic [3:0]  R0_ADDR = 4'h0, R1_ADDR = 4'h0;
  logic [15:0] R0_DATA = 16'h0, R1_DATA = 16'h0;
  logic        R0_ACK, R1_ACK;
  logic [3:0]  CG_ADDR;
  logic [15:0] CG_DI;
  logic        CG_WE, CG_RE;
  logic [31:0] CG_DO;
  logic        BUSY, ERR;
  logic [1:0]  ERR_CODE;

  clk_div_cfg_sched #(.RETRY_MAX(RM), .SETTLE(S)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
    .R0_REQ(R0_REQ), .R0_ADDR(R0_ADDR), .R0_DATA(R0_DATA), .R0_ACK(R0_ACK),
    .R1_REQ(R1_REQ), .R1_ADDR(R1_ADDR), .R1_DATA(R1_DATA), .R1_ACK(R1_ACK),
    .CG_ADDR(CG_ADDR), .CG_DI(CG_DI), .CG_WE(CG_WE), .CG_RE(CG_RE), .CG_DO(CG_DO),
    .BUSY(BUSY), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  // Clock-generator register model: mirrors writes; reads are inverted while rd_count < bad_until.
  int          cyc = 0;
  int          rd_count = 0;
  int          bad_until = 0;
  logic [15:0] mem [16];

  always @(posedge OPB_CLK) begin
    cyc <= cyc + 1;
    if (CG_WE) mem[CG_ADDR] <= CG_DI;
    if (CG_RE) rd_count <= rd_count + 1;
  end

  assign CG_DO = {16'hA5A5, (rd_count < bad_until) ? ~mem[CG_ADDR] : mem[CG_ADDR]};

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          bad;
    int          gap;
    bit          wd;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  bit        e_we[NC], e_re[NC], e_a0[NC], e_a1[NC], e_busy[NC], e_upd[NC];
  bit [3:0]  e_addr[NC];
  bit [15:0] e_di[NC];
  bit [1:0]  e_code[NC];

  int       busy_until = -1;
  bit       last = 1'b1;
  bit       granted[2];
  int       gap[2];
  bit [1:0] cur_code = 2'b00;
  bit       in_rst = 1'b0;
  bit       we_pend = 1'b0;
  int       sched_we = 0;

  int          obs_we[$], obs_re[$], ack_cyc[$], ack_who[$];
  logic [15:0] obs_wd[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic txn_t qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic push(input int i, input txn_t t);
    if (qsize(i) == 0) gap[i] = t.gap;
    if (i == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  // Expected per-cycle outputs for one granted request sampled at posedge p.
  task automatic schedule(input int w, input int p, input txn_t t);
    bit       ok_a, ok_d;
    bit [1:0] code;
    int       pairs, ack, we_c, re_c;
    ok_a = (t.addr != 4'h1) && (t.addr < 4'h8);
    ok_d = (t.data != 16'h0) || (t.addr == 4'h5);
    if (!ok_a || !ok_d) begin
      code = ok_a ? 2'b10 : 2'b01;
      ack  = p + 1;
    end else begin
      pairs = (t.bad > RM) ? RM + 1 : t.bad + 1;
      code  = (t.bad > RM) ? 2'b11 : 2'b00;
      for (int k = 0; k < pairs; k++) begin
        we_c = p + 1 + k * (3 + S);
        re_c = we_c + 1 + S;
        e_we[we_c] = 1'b1; e_addr[we_c] = t.addr; e_di[we_c] = t.data;
        e_re[re_c] = 1'b1; e_addr[re_c] = t.addr;
      end
      ack = p + 1 + pairs * (3 + S);
    end
    sched_we = p + 1;
    for (int k = p; k <= ack; k++) e_busy[k] = 1'b1;
    if (w == 0) e_a0[ack] = 1'b1; else e_a1[ack] = 1'b1;
    e_upd[ack]  = 1'b1;
    e_code[ack] = code;
    busy_until  = ack;
  endtask

  task automatic check_cycle(input int c);
    chk("cg_we", CG_WE, e_we[c]);
    chk("cg_re", CG_RE, e_re[c]);
    chk("cg_addr", CG_ADDR, e_addr[c]);
    chk("cg_di", CG_DI, e_di[c]);
    chk("r0_ack", R0_ACK, e_a0[c]);
    chk("r1_ack", R1_ACK, e_a1[c]);
    chk("busy", BUSY, e_busy[c]);
    if (e_upd[c]) cur_code = e_code[c];
    chk("err", ERR, cur_code != 2'b00);
    if (cur_code != 2'b00) chk("err_code", ERR_CODE, cur_code);
    chk("strobe_overlap", CG_WE & CG_RE, 0);
    if (CG_WE) begin
      chk("we_without_re", we_pend, 0);
      we_pend = 1'b1;
      obs_we.push_back(c);
      obs_wd.push_back(CG_DI);
    end
    if (CG_RE) begin
      chk("re_without_we", we_pend, 1);
      we_pend = 1'b0;
      obs_re.push_back(c);
    end
    if (R0_ACK) begin ack_cyc.push_back(c); ack_who.push_back(0); end
    if (R1_ACK) begin ack_cyc.push_back(c); ack_who.push_back(1); end
  endtask

  task automatic drive(input int c);
    bit   r;
    txn_t h;
    for (int i = 0; i < 2; i++) begin
      if (granted[i] && ((i == 0) ? e_a0[c] : e_a1[c])) begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        granted[i] = 1'b0;
        if (qsize(i) > 0) gap[i] = qhead(i).gap;
      end
      r = 1'b0;
      h = '{addr: 4'h0, data: 16'h0, bad: 0, gap: 0, wd: 1'b0};
      if (qsize(i) > 0) begin
        h = qhead(i);
        if (granted[i]) r = !h.wd;
        else if (gap[i] > 0) gap[i]--;
        else r = 1'b1;
      end
      if (i == 0) begin R0_REQ = r; R0_ADDR = h.addr; R0_DATA = h.data; end
      else        begin R1_REQ = r; R1_ADDR = h.addr; R1_DATA = h.data; end
    end
  endtask

  task automatic model_grant(input int c);
    int   w;
    txn_t t;
    if (!in_rst && c > busy_until && (R0_REQ || R1_REQ)) begin
      w = (R0_REQ && R1_REQ) ? int'(!last) : (R1_REQ ? 1 : 0);
      t = qhead(w);
      granted[w] = 1'b1;
      last = w[0];
      bad_until = rd_count + t.bad;
      schedule(w, c + 1, t);
    end
  endtask

  task automatic step();
    @(negedge OPB_CLK);
    if (cyc >= NC - 64) begin
      n_fail++;
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NC - 64);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "cycle budget exhausted");
    end
    check_cycle(cyc);
    drive(cyc);
    model_grant(cyc);
  endtask

  task automatic run_idle(input int max);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc <= busy_until) && k < max) begin
      step();
      k++;
    end
    chk("drain_timeout", k < max, 1);
    repeat (2) step();
  endtask

  function automatic txn_t mk(input logic [3:0] a, input logic [15:0] d, input int bad);
    return '{addr: a, data: d, bad: bad, gap: 0, wd: 1'b0};
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.addr = 4'($urandom_range(0, 9));
    t.data = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
    t.bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    t.gap  = int'($urandom_range(0, 3));
    t.wd   = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  initial begin
    int c0, nw, nr, na, k;
    #2 OPB_RST = 1'b1;
    repeat (3) begin
      @(negedge OPB_CLK);
      chk("rst_outputs", {R0_ACK, R1_ACK, CG_WE, CG_RE, BUSY, ERR, ERR_CODE, CG_ADDR, CG_DI}, 0);
    end
    OPB_RST = 1'b0;

    // Simultaneous requests: R0 first, then R1 against R0's immediate re-request, then R0.
    na = ack_who.size();
    push(0, mk(4'h3, 16'h1234, 0));
    push(0, mk(4'h4, 16'h0456, 0));
    push(1, mk(4'h5, 16'h0077, 0));
    run_idle(200);
    chk("rr_count", ack_who.size() - na, 3);
    if (ack_who.size() >= na + 3) begin
      chk("rr_first", ack_who[na], 0);
      chk("rr_second", ack_who[na + 1], 1);
      chk("rr_third", ack_who[na + 2], 0);
    end

    // Single good write: latency pins.
    c0 = cyc + 1; nw = obs_we.size(); nr = obs_re.size(); na = ack_cyc.size();
    push(0, mk(4'h2, 16'h07D0, 0));
    run_idle(100);
    chk("A_we_count", obs_we.size() - nw, 1);
    chk("A_re_count", obs_re.size() - nr, 1);
    if (obs_we.size() > nw && obs_re.size() > nr && ack_cyc.size() > na) begin
      chk("A_we_lat", obs_we[nw] - c0, 2);
      chk("A_we_data", obs_wd[nw], 16'h07D0);
      chk("A_re_lat", obs_re[nr] - c0, 4);
      chk("A_ack_lat", ack_cyc[na] - c0, 6);
      chk("A_ack_who", ack_who[na], 0);
    end
    chk("A_err", ERR, 0);

    // Rejections.
    nw = obs_we.size(); nr = obs_re.size(); na = ack_cyc.size();
    push(1, mk(4'h8, 16'h1111, 0));
    run_idle(100);
    chk("C_no_we", obs_we.size() - nw, 0);
    chk("C_no_re", obs_re.size() - nr, 0);
    chk("C_ack", ack_cyc.size() - na, 1);
    chk("C_err", ERR, 1);
    chk("C_code_addr", ERR_CODE, 2'b01);
    push(1, mk(4'h3, 16'h0000, 0));
    run_idle(100);
    chk("C_code_zero", ERR_CODE, 2'b10);
    nw = obs_we.size();
    push(1, mk(4'h5, 16'h0000, 0));
    run_idle(100);
    chk("C_addr5_zero_ok", ERR, 0);
    chk("C_addr5_we", obs_we.size() - nw, 1);

    // Readback never matches.
    nw = obs_we.size(); nr = obs_re.size();
    push(0, mk(4'h6, 16'h0ABC, 99));
    run_idle(200);
    chk("D_we_count", obs_we.size() - nw, 3);
    chk("D_re_count", obs_re.size() - nr, 3);
    chk("D_err", ERR, 1);
    chk("D_code", ERR_CODE, 2'b11);
    push(0, mk(4'h7, 16'h0001, 0));
    run_idle(100);
    chk("D_err_cleared", ERR, 0);

    // Reset during SETTLE.
    na = ack_cyc.size();
    push(0, mk(4'h4, 16'h2222, 0));
    k = 0;
    while (!(granted[0] && cyc == sched_we + 1) && k < 50) begin step(); k++; end
    chk("E_reach_settle", k < 50, 1);
    OPB_RST = 1'b1;
    #1;
    chk("E_rst_outputs", {R0_ACK, R1_ACK, CG_WE, CG_RE, BUSY, ERR, ERR_CODE, CG_ADDR, CG_DI}, 0);
    for (int i = cyc; i < cyc + 64 && i < NC; i++) begin
      e_we[i] = 0; e_re[i] = 0; e_a0[i] = 0; e_a1[i] = 0; e_busy[i] = 0; e_upd[i] = 0;
      e_addr[i] = 0; e_di[i] = 0; e_code[i] = 0;
    end
    q0.delete(); q1.delete();
    granted[0] = 0; granted[1] = 0;
    busy_until = -1; last = 1'b1; cur_code = 2'b00; we_pend = 1'b0; bad_until = rd_count;
    in_rst = 1'b1;
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    repeat (3) step();
    OPB_RST = 1'b0;
    in_rst = 1'b0;
    repeat (3) step();
    chk("E_no_ack", ack_cyc.size() - na, 0);
    push(0, mk(4'h4, 16'h3333, 0));
    run_idle(100);
    chk("E_after_ack", ack_cyc.size() - na, 1);
    chk("E_after_err", ERR, 0);

    // Randomized traffic from both requesters.
    for (int j = 0; j < 120; j++) begin
      push(0, rnd_txn());
      push(1, rnd_txn());
    end
    run_idle(12000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
